// File: rtl/alu_operand_stage.sv
// alu_operand_stage: operand staging FIFO in front of the ALU function units.
// Accepts {op, a, b} requests over a valid/ready handshake and drops illegal
// opcodes with a one-cycle err pulse. Legal requests are tagged with a
// sequence number and issued in order over a second valid/ready handshake.
// All outputs are registered.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous empty of the FIFO (tag counter kept)
//   in_valid/in_ready     request handshake; in_op, in_a, in_b payload
//   out_valid/out_ready   issue handshake; out_op, out_a, out_b, out_tag head
//   count                 current occupancy
//   err                   one-cycle pulse per dropped illegal request
module alu_operand_stage #(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned OPW     = 3,
   parameter int unsigned NUM_OPS = 6,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TAGW    = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [OPW-1:0]             in_op,
   input  logic [WIDTH-1:0]           in_a,
   input  logic [WIDTH-1:0]           in_b,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [OPW-1:0]             out_op,
   output logic [WIDTH-1:0]           out_a,
   output logic [WIDTH-1:0]           out_b,
   output logic [TAGW-1:0]            out_tag,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       err
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef struct packed {
      logic [OPW-1:0]   op;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [TAGW-1:0]  tag;
   } entry_t;

   entry_t          mem [DEPTH];
   entry_t          head_q, head_n, wr_entry;
   logic [PW-1:0]   wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
   logic [CW-1:0]   count_n;
   logic [TAGW-1:0] tag_ctr, tag_ctr_n;
   logic            accept, legal, wr_en, rd_en;
   logic            in_ready_n, out_valid_n, err_n;

   // Next-state computation for pointers, occupancy, tag and registered head
   always_comb begin
      accept      = in_valid && in_ready;
      legal       = 32'(in_op) < NUM_OPS;
      wr_en       = accept && legal && !flush;
      rd_en       = out_valid && out_ready && !flush;
      wr_entry    = '{op: in_op, a: in_a, b: in_b, tag: tag_ctr};

      wr_ptr_n    = wr_ptr + PW'(wr_en);
      rd_ptr_n    = rd_ptr + PW'(rd_en);
      count_n     = count + CW'(wr_en) - CW'(rd_en);
      tag_ctr_n   = tag_ctr + TAGW'(wr_en);
      err_n       = accept && !legal && !flush;

      if (flush) begin
         wr_ptr_n = '0;
         rd_ptr_n = '0;
         count_n  = '0;
      end

      in_ready_n  = count_n < CW'(DEPTH);
      out_valid_n = count_n != '0;

      // The new head is the entry being written this edge only when the
      // write lands on the slot the read pointer moves to (FIFO was drained).
      head_n = '0;
      if (out_valid_n) begin
         if (wr_en && (wr_ptr == rd_ptr_n)) head_n = wr_entry;
         else                               head_n = mem[rd_ptr_n];
      end
   end

   // Control and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         tag_ctr   <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         err       <= 1'b0;
         head_q    <= '0;
      end else begin
         wr_ptr    <= wr_ptr_n;
         rd_ptr    <= rd_ptr_n;
         count     <= count_n;
         tag_ctr   <= tag_ctr_n;
         in_ready  <= in_ready_n;
         out_valid <= out_valid_n;
         err       <= err_n;
         head_q    <= head_n;
      end
   end

   // Storage array; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wr_entry;
   end

   assign out_op  = head_q.op;
   assign out_a   = head_q.a;
   assign out_b   = head_q.b;
   assign out_tag = head_q.tag;

endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush, in_valid, in_ready, out_valid, out_ready, err;
   logic [2:0]  in_op, out_op;
   logic [15:0] in_a, in_b, out_a, out_b;
   logic [3:0]  out_tag;
   logic [2:0]  count;

   alu_operand_stage dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_op(out_op), .out_a(out_a), .out_b(out_b), .out_tag(out_tag),
      .count(count), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  tag;
   } ent_t;

   typedef struct {
      logic        v;
      logic [2:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic        rdy;
      logic        fl;
      int          exp_count;
      logic        exp_err;
   } vec_t;

   // Scoreboard model
   ent_t       q[$];
   logic [3:0] m_tag;
   logic       m_ready;
   logic       m_err;
   int         checks = 0;
   int         failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_tag   = '0;
      m_ready = 1'b0;
      m_err   = 1'b0;
   endtask

   task automatic check_state(input string tag);
      ent_t h;
      h = (q.size() > 0) ? q[0] : '0;
      chk({tag, ".count"},     64'(count),     64'(q.size()));
      chk({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() > 0));
      chk({tag, ".in_ready"},  64'(in_ready),  64'(m_ready));
      chk({tag, ".err"},       64'(err),       64'(m_err));
      chk({tag, ".head"}, 64'({out_op, out_a, out_b, out_tag}), 64'(h));
   endtask

   // One clock cycle: drive, update model at the edge, check 1 time unit later
   task automatic step(input logic v, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic rdy, input logic fl);
      logic acc, iss;
      in_valid  = v;
      in_op     = op;
      in_a      = a;
      in_b      = b;
      out_ready = rdy;
      flush     = fl;
      @(posedge clk);
      acc = v && m_ready;
      iss = rdy && (q.size() > 0);
      if (fl) begin
         q.delete();
         m_err = 1'b0;
      end else begin
         if (iss) void'(q.pop_front());
         if (acc && op < 3'd6) begin
            q.push_back('{op: op, a: a, b: b, tag: m_tag});
            m_tag = m_tag + 4'd1;
         end
         m_err = acc && !(op < 3'd6);
      end
      m_ready = q.size() < 4;
      #1;
      check_state("step");
   endtask

   vec_t vecs[18];

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      // Hand-computed expected occupancy and err for directed rows
      vecs[0]  = '{1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 0, 1'b0};
      vecs[1]  = '{1'b1, 3'd0, 16'hFFFF, 16'h0F0F, 1'b0, 1'b0, 1, 1'b0};
      vecs[2]  = '{1'b0, 3'd0, 16'h0000, 16'h0000, 1'b1, 1'b0, 0, 1'b0};
      vecs[3]  = '{1'b1, 3'd1, 16'd1,    16'h0000, 1'b0, 1'b0, 1, 1'b0};
      vecs[4]  = '{1'b1, 3'd1, 16'd2,    16'h0000, 1'b0, 1'b0, 2, 1'b0};
      vecs[5]  = '{1'b1, 3'd1, 16'd3,    16'h0000, 1'b0, 1'b0, 3, 1'b0};
      vecs[6]  = '{1'b1, 3'd1, 16'd4,    16'h0000, 1'b0, 1'b0, 4, 1'b0};
      vecs[7]  = '{1'b1, 3'd1, 16'd5,    16'h0000, 1'b0, 1'b0, 4, 1'b0};
      vecs[8]  = '{1'b0, 3'd0, 16'h0000, 16'h0000, 1'b1, 1'b0, 3, 1'b0};
      vecs[9]  = '{1'b0, 3'd0, 16'h0000, 16'h0000, 1'b1, 1'b0, 2, 1'b0};
      vecs[10] = '{1'b0, 3'd0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1, 1'b0};
      vecs[11] = '{1'b0, 3'd0, 16'h0000, 16'h0000, 1'b1, 1'b0, 0, 1'b0};
      vecs[12] = '{1'b0, 3'd0, 16'h0000, 16'h0000, 1'b1, 1'b0, 0, 1'b0};
      vecs[13] = '{1'b1, 3'd1, 16'd10,   16'h0001, 1'b0, 1'b0, 1, 1'b0};
      vecs[14] = '{1'b1, 3'd7, 16'd11,   16'h0002, 1'b0, 1'b0, 1, 1'b1};
      vecs[15] = '{1'b1, 3'd2, 16'd12,   16'h0003, 1'b0, 1'b0, 2, 1'b0};
      vecs[16] = '{1'b0, 3'd0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1, 1'b0};
      vecs[17] = '{1'b0, 3'd0, 16'h0000, 16'h0000, 1'b1, 1'b0, 0, 1'b0};

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_op = '0; in_a = '0; in_b = '0;
      model_reset();
      #1;
      check_state("reset");
      #11 rst_n = 1'b1;

      for (int i = 0; i < 18; i++) begin
         step(vecs[i].v, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rdy, vecs[i].fl);
         chk($sformatf("vec%0d.count", i), 64'(count), 64'(vecs[i].exp_count));
         chk($sformatf("vec%0d.err", i),   64'(err),   64'(vecs[i].exp_err));
         if (i == 1) chk("single.tag", 64'(out_tag), 64'd0);
      end

      // Streaming: one accept and one issue per cycle, tags wrap
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 3'(i % 6), 16'(100 + i), 16'(i), 1'b1, 1'b0);
         if (i > 0) chk("stream.count", 64'(count), 64'd1);
      end
      step(1'b0, 3'd0, 16'd0, 16'd0, 1'b1, 1'b0);

      // Flush with three entries and a simultaneous legal request
      step(1'b1, 3'd3, 16'hA001, 16'd1, 1'b0, 1'b0);
      step(1'b1, 3'd4, 16'hA002, 16'd2, 1'b0, 1'b0);
      step(1'b1, 3'd5, 16'hA003, 16'd3, 1'b0, 1'b0);
      step(1'b1, 3'd0, 16'hA004, 16'd4, 1'b1, 1'b1);
      chk("flush.count", 64'(count), 64'd0);
      step(1'b1, 3'd1, 16'hB000, 16'd5, 1'b0, 1'b0);
      // Illegal request in a flush cycle raises no err
      step(1'b1, 3'd7, 16'hB001, 16'd6, 1'b0, 1'b1);
      chk("flush_illegal.err", 64'(err), 64'd0);

      // Asynchronous reset mid-operation with two entries queued
      step(1'b1, 3'd2, 16'hC001, 16'd7, 1'b0, 1'b0);
      step(1'b1, 3'd2, 16'hC002, 16'd8, 1'b0, 1'b0);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      check_state("midreset");
      @(posedge clk);
      #1 rst_n = 1'b1;
      step(1'b0, 3'd0, 16'd0, 16'd0, 1'b0, 1'b0);
      step(1'b1, 3'd4, 16'hD000, 16'd9, 1'b0, 1'b0);
      chk("postreset.tag", 64'(out_tag), 64'd0);
      step(1'b0, 3'd0, 16'd0, 16'd0, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
